soc_sysid_ext: RTL and testbench
================================

// Module: soc_sysid_ext
// PURPOSE
//  Parametrised system-ID and uptime peripheral. It is an Avalon-MM slave on the SoC interconnect
//  and is the successor to the single-word combinational sysid slave. Besides the ID it returns a
//  build timestamp, a config word, a prescaled 64-bit uptime counter with atomic hi/lo snapshot,
//  and N scratch registers. Reads are pipelined with a fixed latency of 1 and use readdatavalid.
// PARAMETERS
//  SYSID_ID     32'h6242_A22A  system ID word (read at word 0)
//  TIMESTAMP    32'h0          build timestamp in Unix seconds (read at word 1)
//  PRESCALE     1              clock cycles per uptime tick; legal range 1..65535
//  UPTIME_W     64             uptime counter width; legal range 33..64
//  N_SCRATCH    2              number of R/W scratch words; legal range 1..10
//  ADDR_W       4              word-address width; must satisfy 2**ADDR_W >= 6+N_SCRATCH
// PORTS
//  clock          in   1       single clock for the whole block
//  reset          in   1       synchronous, active-high reset
//  address        in   ADDR_W  word address
//  read           in   1       read strobe, one cycle per request
//  write          in   1       write strobe, one cycle per request
//  writedata      in   32      write data
//  readdata       out  32      read data; valid while readdatavalid=1
//  readdatavalid  out  1       pulses exactly 1 cycle after each accepted read
// BEHAVIOUR
//  Register map (word addresses):
//   0: ID (RO) = SYSID_ID
//   1: TIMESTAMP (RO)
//   2: INFO (RO) = {PRESCALE[15:0], UPTIME_W[7:0], N_SCRATCH[7:0]}
//   3: CTRL (RW): bit0 RUN (reset value 1); bit1 CLEAR (write-1 pulse, always reads 0); other bits read 0
//   4: UPTIME_LO (RO): reading returns cnt[31:0] and, on the same edge, copies cnt[UPTIME_W-1:32] into HI_SNAP
//   5: UPTIME_HI (RO) = HI_SNAP, zero-extended to 32 bits
//   6..5+N_SCRATCH: SCRATCHk (RW), reset value 0
//   Other addresses: read returns 0; writes are ignored. Writes to RO words are ignored.
//  Timing and handshake:
//   - No waitrequest; every strobe is accepted in the cycle it is asserted.
//   - A read at edge T gives readdatavalid=1 and readdata at T+1. Back-to-back reads give
//     back-to-back valids.
//   - readdata holds its last value while readdatavalid=0.
//   - read and write in the same cycle: both are performed, and the read returns the
//     pre-write value.
//   - A write takes effect at the edge it is sampled.
//  Uptime:
//   - Prescaler pcnt counts 0..PRESCALE-1 while RUN=1.
//   - When pcnt==PRESCALE-1, pcnt goes to 0 and cnt increments by 1.
//   - cnt wraps from all-ones to 0 with no flag.
//   - RUN=0 freezes both pcnt and cnt.
//   - Writing CTRL with bit1=1 zeroes cnt, pcnt and HI_SNAP at that edge.
//   - Clear takes priority over an increment in the same cycle.
//   - The RUN bit from the same write is applied at the same edge.
//   - A UPTIME_LO read in the same cycle as a clear returns the pre-clear value and snapshots the
//     pre-clear hi; the clear then zeroes HI_SNAP, so clear wins.
//  Reset (synchronous, active-high):
//   - readdata=0, readdatavalid=0.
//   - cnt, pcnt, HI_SNAP and scratch = 0; RUN=1.
//   - A read pending at the edge where reset is asserted is dropped: no valid is produced
//     in the next cycle.
// TESTING
//  1. Reset, then read addr 0,1,2 back-to-back -> valids at T+1..T+3 with data SYSID_ID,
//     TIMESTAMP, 32'h0001_4002.
//  2. PRESCALE=4: release reset, wait 40 cycles, read LO -> value 9 or 10.
//     Read HI -> 0. Valid is exactly 1 cycle after each read.
//  3. Force cnt=64'h0000_0000_FFFF_FFFF:
//      - Read LO -> FFFF_FFFF.
//      - Advance 1 tick, read HI -> 0 (snapshot held).
//      - Re-read LO -> 0, then HI -> 1.
//  4. Write CTRL=0, wait 20 cycles -> LO is unchanged.
//     Write CTRL=3 -> LO reads 0 or 1; CTRL reads 1.
//  5. Write SCRATCH0=DEADBEEF with a simultaneous read of addr 6 -> old value 0.
//     Next read -> DEADBEEF. Unmapped addr 15 reads 0.
//  6. Issue a read and assert reset on the same edge -> readdatavalid=0 next cycle;
//     scratch=0 and RUN=1 afterwards.

Source files
------------

// File: rtl/soc_sysid_ext.sv
// System-ID / uptime Avalon-MM slave with build info, CTRL, 64-bit uptime and scratch words.
// Latency: reads return readdata with readdatavalid exactly one cycle after the read strobe.
// Backpressure: none; every read/write strobe is accepted in the cycle it is asserted.
module soc_sysid_ext #(
  parameter logic [31:0] SYSID_ID  = 32'h6242_A22A,
  parameter logic [31:0] TIMESTAMP = 32'h0,
  parameter int          PRESCALE  = 1,
  parameter int          UPTIME_W  = 64,
  parameter int          N_SCRATCH = 2,
  parameter int          ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int HI_W = UPTIME_W - 32;
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam logic [31:0] INFO = {16'(PRESCALE), 8'(UPTIME_W), 8'(N_SCRATCH)};

  logic [31:0]         addr_w;
  logic                ctrl_wr;
  logic                clear;
  logic                lo_rd;

  logic [15:0]         pcnt_q, pcnt_d;
  logic [UPTIME_W-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]     hi_snap_q, hi_snap_d;
  logic                run_q, run_d;
  logic [31:0]         scratch_q [N_SCRATCH];
  logic [31:0]         scratch_d [N_SCRATCH];
  logic [31:0]         rdata;
  logic [31:0]         readdata_q, readdata_d;
  logic                rvalid_q;

  assign addr_w  = 32'(address);
  assign ctrl_wr = write && (addr_w == 32'd3);
  assign clear   = ctrl_wr && writedata[1];
  assign lo_rd   = read && (addr_w == 32'd4);

  // Prescaler / uptime / snapshot next state; clear beats both increment and snapshot.
  always_comb begin
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    hi_snap_d = hi_snap_q;
    run_d     = run_q;
    if (ctrl_wr) run_d = writedata[0];
    if (lo_rd) hi_snap_d = cnt_q[UPTIME_W-1:32];
    if (run_q) begin
      if (pcnt_q == PS_LAST) begin
        pcnt_d = 16'd0;
        cnt_d  = cnt_q + 1'b1;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end
    if (clear) begin
      pcnt_d    = 16'd0;
      cnt_d     = '0;
      hi_snap_d = '0;
    end
  end

  // Scratch write decode: one word updated per write strobe.
  always_comb begin
    for (int k = 0; k < N_SCRATCH; k++) begin
      scratch_d[k] = scratch_q[k];
      if (write && (addr_w == 32'(6 + k))) scratch_d[k] = writedata;
    end
  end

  // Read mux over pre-write state so a same-cycle write is not visible to the read.
  always_comb begin
    rdata = 32'd0;
    case (addr_w)
      32'd0: rdata = SYSID_ID;
      32'd1: rdata = TIMESTAMP;
      32'd2: rdata = INFO;
      32'd3: rdata = {31'd0, run_q};
      32'd4: rdata = cnt_q[31:0];
      32'd5: rdata = 32'(hi_snap_q);
      default: begin
        for (int k = 0; k < N_SCRATCH; k++) begin
          if (addr_w == 32'(6 + k)) rdata = scratch_q[k];
        end
      end
    endcase
    readdata_d = read ? rdata : readdata_q;
  end

  // State registers; reset drops any read sampled on the reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q     <= 16'd0;
      cnt_q      <= '0;
      hi_snap_q  <= '0;
      run_q      <= 1'b1;
      readdata_q <= 32'd0;
      rvalid_q   <= 1'b0;
      for (int k = 0; k < N_SCRATCH; k++) scratch_q[k] <= 32'd0;
    end else begin
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      hi_snap_q  <= hi_snap_d;
      run_q      <= run_d;
      readdata_q <= readdata_d;
      rvalid_q   <= read;
      for (int k = 0; k < N_SCRATCH; k++) scratch_q[k] <= scratch_d[k];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_soc_sysid_ext.sv
// Directed self-checking bench for soc_sysid_ext (PRESCALE=4 instance).
// Latency: every read is checked for valid exactly one cycle later.
// Backpressure: not applicable; DUT accepts every strobe.
module tb_soc_sysid_ext;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  always #5 clock = ~clock;

  soc_sysid_ext #(
    .SYSID_ID (32'h6242_A22A),
    .TIMESTAMP(32'h5F5E_1000),
    .PRESCALE (4),
    .UPTIME_W (64),
    .N_SCRATCH(2),
    .ADDR_W   (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Single read: strobe for one edge, then valid must be high and data captured.
  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    step();
    read = 1'b0;
    chk("read_valid", 32'(readdatavalid), 32'd1);
    d = readdata;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    step(); step();
    chk("reset_valid", 32'(readdatavalid), 32'd0);
    chk("reset_data", readdata, 32'd0);
    reset = 1'b0;

    // 1. back-to-back ID / TIMESTAMP / INFO reads
    address = 4'd0; read = 1'b1; step();
    chk("b2b_v0", 32'(readdatavalid), 32'd1);
    chk("id", readdata, 32'h6242_A22A);
    address = 4'd1; step();
    chk("b2b_v1", 32'(readdatavalid), 32'd1);
    chk("timestamp", readdata, 32'h5F5E_1000);
    address = 4'd2; step();
    read = 1'b0;
    chk("b2b_v2", 32'(readdatavalid), 32'd1);
    chk("info", readdata, 32'h0004_4002);
    step();
    chk("valid_drop", 32'(readdatavalid), 32'd0);
    chk("data_hold", readdata, 32'h0004_4002);

    // 2. uptime after reset release with PRESCALE=4
    reset = 1'b1; step(); reset = 1'b0;
    repeat (40) step();
    do_read(4'd4, rd);
    chk("uptime_9_or_10", 32'(rd == 32'd9 || rd == 32'd10), 32'd1);
    step();
    chk("valid_single", 32'(readdatavalid), 32'd0);
    do_read(4'd5, rd);
    chk("uptime_hi0", rd, 32'd0);

    // 3. hi/lo snapshot across the 32-bit boundary (counter frozen while forced)
    do_write(4'd3, 32'd0);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    force dut.pcnt_q = 16'd3;
    step();
    release dut.cnt_q;
    release dut.pcnt_q;
    step();
    do_read(4'd4, rd);
    chk("lo_ffff", rd, 32'hFFFF_FFFF);
    do_write(4'd3, 32'd1);   // RUN=1: next edge is the terminal prescale count
    do_write(4'd3, 32'd0);   // that edge ticks once, then freeze
    do_read(4'd5, rd);
    chk("hi_snap_held", rd, 32'd0);
    do_read(4'd4, rd);
    chk("lo_wrapped", rd, 32'd0);
    do_read(4'd5, rd);
    chk("hi_one", rd, 32'd1);

    // 4. RUN=0 freezes, CLEAR zeroes, CLEAR reads back 0
    do_write(4'd3, 32'd0);
    repeat (20) step();
    do_read(4'd4, rd);
    chk("frozen_lo", rd, 32'd0);
    do_read(4'd5, rd);
    chk("frozen_hi", rd, 32'd1);
    do_write(4'd3, 32'd3);
    do_read(4'd4, rd);
    chk("clear_lo_0_or_1", 32'(rd == 32'd0 || rd == 32'd1), 32'd1);
    do_read(4'd5, rd);
    chk("clear_hi", rd, 32'd0);
    do_read(4'd3, rd);
    chk("ctrl_read", rd, 32'd1);

    // 5. scratch read-during-write, RO write ignored, unmapped reads 0
    address = 4'd6; writedata = 32'hDEAD_BEEF; write = 1'b1; read = 1'b1;
    step();
    write = 1'b0; read = 1'b0;
    chk("rdw_valid", 32'(readdatavalid), 32'd1);
    chk("rdw_old", readdata, 32'd0);
    do_read(4'd6, rd);
    chk("scratch0", rd, 32'hDEAD_BEEF);
    do_write(4'd7, 32'h1234_5678);
    do_read(4'd7, rd);
    chk("scratch1", rd, 32'h1234_5678);
    do_read(4'd15, rd);
    chk("unmapped", rd, 32'd0);
    do_write(4'd0, 32'h0BAD_F00D);
    do_read(4'd0, rd);
    chk("id_ro", rd, 32'h6242_A22A);

    // 6. read on the reset edge is dropped; reset restores scratch and RUN
    do_write(4'd3, 32'd0);
    address = 4'd6; read = 1'b1; reset = 1'b1;
    step();
    read = 1'b0; reset = 1'b0;
    chk("reset_drop_valid", 32'(readdatavalid), 32'd0);
    do_read(4'd6, rd);
    chk("reset_scratch", rd, 32'd0);
    do_read(4'd3, rd);
    chk("reset_run", rd, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
